mem_responder: RTL and testbench

//  Memory-side responder for the cache controller's refill/write-through port.

---
 rtl/mem_responder_pkg.sv | 20 ++
 rtl/mem_responder_mem_array.sv | 32 +++
 rtl/mem_responder.sv | 144 ++++++++++++++
 tb/tb_mem_responder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared defaults, FSM state encoding and operation codes for the memory responder.
package mem_responder_pkg;

  localparam int DEF_AW      = 8;
  localparam int DEF_DW      = 8;
  localparam int DEF_LATENCY = 4;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_BUSY = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

endpackage

// File: rtl/mem_responder_mem_array.sv
// Single-port synchronous RAM, 2**AW x DW, one read or write per enabled cycle.
// Read data is registered and has no reset; the owner decides when it is meaningful.
module mem_array
  import mem_responder_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          i_en,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        r_mem[i_addr] <= i_wdata;
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: one request at a time, response pulse LATENCY cycles after
// acceptance, storage zeroed after every reset; requests while not ready are ignored.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          mem_read_en,
  input  logic          mem_write_en,
  input  logic [AW-1:0] mem_address,
  input  logic [DW-1:0] mem_write_data,
  output logic          mem_ready,
  output logic          mem_valid,
  output logic [DW-1:0] mem_read_data,
  output logic          protocol_err
);

  localparam int            CW        = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] LAT_LAST  = CW'(LATENCY - 1);
  localparam logic [AW:0]   INIT_LAST = {1'b0, {AW{1'b1}}};

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW:0]   r_init_cnt;
  logic [CW-1:0] r_lat_cnt;
  op_t           r_op;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_read_data;
  logic          r_perr;

  logic          w_req;
  logic          w_accept;
  logic          w_ram_en;
  logic          w_ram_we;
  logic [AW-1:0] w_ram_addr;
  logic [DW-1:0] w_ram_wdata;
  logic [DW-1:0] w_ram_rdata;

  assign w_req = mem_read_en | mem_write_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    mem_ready   = 1'b0;
    mem_valid   = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      ST_INIT: begin
        if (r_init_cnt == INIT_LAST) w_state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        mem_ready = 1'b1;
        if (w_req) begin
          w_accept    = 1'b1;
          w_state_nxt = (LATENCY > 1) ? ST_BUSY : ST_RESP;
        end
      end
      ST_BUSY: begin
        if (r_lat_cnt == LAT_LAST) w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        mem_valid   = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_init_cnt  <= '0;
      r_lat_cnt   <= '0;
      r_op        <= OP_READ;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_read_data <= '0;
      r_perr      <= 1'b0;
    end else begin
      if (r_state == ST_INIT) r_init_cnt <= r_init_cnt + (AW + 1)'(1);
      if (w_accept) begin
        // Simultaneous read+write is resolved as a write and remembered as an error.
        r_op      <= mem_write_en ? OP_WRITE : OP_READ;
        r_addr    <= mem_address;
        r_wdata   <= mem_write_data;
        r_lat_cnt <= CW'(1);
        if (mem_read_en && mem_write_en) r_perr <= 1'b1;
      end else if (r_state == ST_BUSY) begin
        r_lat_cnt <= r_lat_cnt + CW'(1);
      end
      if (r_state == ST_RESP && r_op == OP_READ) r_read_data <= w_ram_rdata;
    end
  end

  // The RAM is driven in the cycle before RESP so the access lands on the RESP entry edge.
  always_comb begin
    w_ram_en    = 1'b0;
    w_ram_we    = 1'b0;
    w_ram_addr  = r_addr;
    w_ram_wdata = r_wdata;
    if (r_state == ST_INIT) begin
      w_ram_en    = 1'b1;
      w_ram_we    = 1'b1;
      w_ram_addr  = r_init_cnt[AW-1:0];
      w_ram_wdata = '0;
    end else if (w_state_nxt == ST_RESP) begin
      w_ram_en = 1'b1;
      if (r_state == ST_IDLE) begin
        w_ram_we    = mem_write_en;
        w_ram_addr  = mem_address;
        w_ram_wdata = mem_write_data;
      end else begin
        w_ram_we = (r_op == OP_WRITE);
      end
    end
  end

  mem_array #(
    .AW(AW),
    .DW(DW)
  ) u_mem_array (
    .clk    (clk),
    .i_en   (w_ram_en),
    .i_we   (w_ram_we),
    .i_addr (w_ram_addr),
    .i_wdata(w_ram_wdata),
    .o_rdata(w_ram_rdata)
  );

  assign mem_read_data = (r_state == ST_RESP && r_op == OP_READ) ? w_ram_rdata : r_read_data;
  assign protocol_err  = r_perr;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a LATENCY=4 instance and a LATENCY=1 instance.
module tb_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst4_n = 1'b0, rd4 = 1'b0, wr4 = 1'b0;
  logic [7:0] addr4 = 8'h00, wd4 = 8'h00;
  logic       rdy4, vld4, perr4;
  logic [7:0] rdat4;

  logic       rst1_n = 1'b0, rd1 = 1'b0, wr1 = 1'b0;
  logic [7:0] addr1 = 8'h00, wd1 = 8'h00;
  logic       rdy1, vld1, perr1;
  logic [7:0] rdat1;

  mem_responder #(.AW(8), .DW(8), .LATENCY(4)) dut4 (
    .clk(clk), .reset_n(rst4_n), .mem_read_en(rd4), .mem_write_en(wr4),
    .mem_address(addr4), .mem_write_data(wd4), .mem_ready(rdy4), .mem_valid(vld4),
    .mem_read_data(rdat4), .protocol_err(perr4)
  );

  mem_responder #(.AW(8), .DW(8), .LATENCY(1)) dut1 (
    .clk(clk), .reset_n(rst1_n), .mem_read_en(rd1), .mem_write_en(wr1),
    .mem_address(addr1), .mem_write_data(wd1), .mem_ready(rdy1), .mem_valid(vld1),
    .mem_read_data(rdat1), .protocol_err(perr1)
  );

  typedef struct {
    logic       rd;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
    logic       exp_perr;
  } vec_t;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic get_rdy(input int w);
    return (w == 1) ? rdy1 : rdy4;
  endfunction

  function automatic logic get_vld(input int w);
    return (w == 1) ? vld1 : vld4;
  endfunction

  function automatic logic get_perr(input int w);
    return (w == 1) ? perr1 : perr4;
  endfunction

  function automatic logic [7:0] get_rdat(input int w);
    return (w == 1) ? rdat1 : rdat4;
  endfunction

  task automatic drive(input int w, input logic rd, input logic wr,
                       input logic [7:0] a, input logic [7:0] d);
    if (w == 1) begin
      rd1 = rd; wr1 = wr; addr1 = a; wd1 = d;
    end else begin
      rd4 = rd; wr4 = wr; addr4 = a; wd4 = d;
    end
  endtask

  task automatic wait_ready(input int w, input string tag);
    int n;
    n = 0;
    while (!get_rdy(w) && n < 1000) begin
      tick();
      n++;
    end
    if (!get_rdy(w)) chk({tag, " ready_timeout"}, int'(get_rdy(w)), 1);
  endtask

  // Latency is reported as the number of rising edges from acceptance to the edge
  // that first samples mem_valid high.
  task automatic do_req(input int w, input logic rd, input logic wr,
                        input logic [7:0] a, input logic [7:0] d, input int lat,
                        input logic [7:0] exp_rd, input logic exp_perr, input string tag);
    int n;
    wait_ready(w, tag);
    drive(w, rd, wr, a, d);
    tick();
    drive(w, 1'b0, 1'b0, a, d);
    n = 0;
    while (!get_vld(w) && n < 50) begin
      tick();
      n++;
    end
    chk({tag, " latency"}, n + 1, lat);
    chk({tag, " rdata"}, int'(get_rdat(w)), int'(exp_rd));
    chk({tag, " perr"}, int'(get_perr(w)), int'(exp_perr));
    tick();
    chk({tag, " pulse_end"}, int'({get_vld(w), get_rdy(w)}), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    vec_t       vecs[8];
    int         n;
    int         cnt_v;
    int         cnt_r;
    int         bad;
    logic       seen;
    logic       rdy_seen;
    logic [7:0] cap;

    vecs[0] = '{1'b1, 1'b0, 8'h7F, 8'h00, 8'h00, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 8'h10, 8'hAA, 8'h00, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 8'h10, 8'h00, 8'hAA, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 8'h20, 8'h55, 8'hAA, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 8'h20, 8'h00, 8'h55, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 8'hFF, 8'h00, 8'h00, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 8'h00, 8'h3C, 8'h00, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 8'h00, 8'h00, 8'h3C, 1'b1};

    // Reset state and INIT duration
    tick();
    tick();
    chk("rst_ready", int'(rdy4), 0);
    chk("rst_valid", int'(vld4), 0);
    chk("rst_rdata", int'(rdat4), 0);
    chk("rst_perr", int'(perr4), 0);
    chk("rst1_ready", int'(rdy1), 0);
    rst4_n = 1'b1;
    rst1_n = 1'b1;
    n = 0;
    while (!rdy4 && n < 400) begin
      tick();
      n++;
    end
    chk("init_cycles", n, 256);
    chk("init1_ready", int'(rdy1), 1);

    for (int i = 0; i < 8; i++) begin
      do_req(0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, 4,
             vecs[i].exp_rdata, vecs[i].exp_perr, $sformatf("vec%0d", i));
    end

    // Request pulsed during BUSY must be ignored
    wait_ready(0, "busy");
    drive(0, 1'b1, 1'b0, 8'h10, 8'h00);
    tick();
    drive(0, 1'b1, 1'b0, 8'h20, 8'h00);
    tick();
    drive(0, 1'b0, 1'b0, 8'h20, 8'h00);
    cnt_v = 0;
    rdy_seen = 1'b0;
    cap = 8'h00;
    for (int k = 0; k < 12; k++) begin
      if (vld4) begin
        cnt_v++;
        cap = rdat4;
      end else if (cnt_v == 0 && rdy4) begin
        rdy_seen = 1'b1;
      end
      tick();
    end
    chk("busy_valids", cnt_v, 1);
    chk("busy_ready", int'(rdy_seen), 0);
    chk("busy_rdata", int'(cap), 'hAA);

    // Reset in the middle of a write's BUSY phase
    wait_ready(0, "midrst");
    drive(0, 1'b0, 1'b1, 8'h10, 8'h77);
    tick();
    drive(0, 1'b0, 1'b0, 8'h10, 8'h77);
    tick();
    rst4_n = 1'b0;
    #1;
    chk("midrst_valid", int'(vld4), 0);
    chk("midrst_ready", int'(rdy4), 0);
    chk("midrst_perr", int'(perr4), 0);
    chk("midrst_rdata", int'(rdat4), 0);
    tick();
    tick();
    rst4_n = 1'b1;
    n = 0;
    seen = 1'b0;
    while (!rdy4 && n < 400) begin
      tick();
      n++;
      if (vld4) seen = 1'b1;
    end
    chk("midrst_init_cycles", n, 256);
    chk("midrst_no_resp", int'(seen), 0);
    do_req(0, 1'b1, 1'b0, 8'h10, 8'h00, 4, 8'h00, 1'b0, "midrst_read");

    // LATENCY=1 instance
    do_req(1, 1'b0, 1'b1, 8'hFF, 8'h3C, 1, 8'h00, 1'b0, "l1_wr");
    do_req(1, 1'b1, 1'b0, 8'hFF, 8'h00, 1, 8'h3C, 1'b0, "l1_rd");
    wait_ready(1, "l1_b2b");
    drive(1, 1'b1, 1'b0, 8'hFF, 8'h00);
    cnt_v = 0;
    cnt_r = 0;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (vld1) begin
        cnt_v++;
        if (rdat1 !== 8'h3C) bad++;
      end
      if (rdy1) cnt_r++;
    end
    drive(1, 1'b0, 1'b0, 8'hFF, 8'h00);
    chk("l1_b2b_valids", cnt_v, 5);
    chk("l1_b2b_ready", cnt_r, 5);
    chk("l1_b2b_rdata_bad", bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
